// File: rtl/paddle_controller.sv
// -----------------------------------------------------------------------------
// paddle_controller
//
// Turns single-cycle press pulses from the up/down debouncers into smooth
// paddle moves of STEP pixels. The paddle moves one pixel per video frame
// tick and always stays inside [Y_MIN, Y_MAX].
//
// Handshake: there is no valid/ready pair. UP_P, DN_P and FRAME_TICK are
// fire-and-forget one-cycle strobes, sampled on the rising CLK edge. There is
// no backpressure, so a pulse the FSM cannot use is simply dropped.
//
// Ports:
//   CLK        in   system clock, all state on the rising edge
//   RESET      in   asynchronous active-low reset
//   UP_P       in   one-cycle "up" press pulse
//   DN_P       in   one-cycle "down" press pulse
//   FRAME_TICK in   one-cycle pulse per video frame (moves one pixel)
//   FREEZE     in   level-sensitive pause; cancels any move, holds Y and DIR
//   PADDLE_Y   out  registered paddle top Y
//   MOVING     out  high while a move is in progress (FSM not IDLE)
//   DIR        out  direction of current/most recent move, 0 = up, 1 = down
// -----------------------------------------------------------------------------
module paddle_controller #(
    parameter int W        = 10,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 400,
    parameter int Y_INIT   = 200,
    parameter int STEP     = 16,
    parameter int PEND_MAX = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         UP_P,
    input  logic         DN_P,
    input  logic         FRAME_TICK,
    input  logic         FREEZE,
    output logic [W-1:0] PADDLE_Y,
    output logic         MOVING,
    output logic         DIR
);

    localparam int REM_MAX = PEND_MAX * STEP;
    localparam int RW      = $clog2(REM_MAX + 1);

    localparam logic [W-1:0]  YMIN_W = W'(Y_MIN);
    localparam logic [W-1:0]  YMAX_W = W'(Y_MAX);
    localparam logic [W-1:0]  YINI_W = W'(Y_INIT);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] rem, rem_n;
    logic [W-1:0]  y_q, y_n;
    logic          dir_q, dir_n;

    // Values after any same-cycle tick (y_t, rem_t) and helpers.
    logic [W-1:0]  y_t;
    logic [RW-1:0] rem_t;
    logic [RW-1:0] rem_add;
    int            rem_sum;
    logic          up_only, dn_only;
    logic          at_min, at_max;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            rem   <= '0;
            y_q   <= YINI_W;
            dir_q <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            y_q   <= y_n;
            dir_q <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        y_n     = y_q;
        dir_n   = dir_q;

        up_only = UP_P & ~DN_P;
        dn_only = DN_P & ~UP_P;

        // While moving, rem >= 1 and Y is strictly inside the bound being
        // approached, so neither decrement below can wrap.
        y_t   = y_q;
        rem_t = rem;
        if (FRAME_TICK && (state != IDLE)) begin
            y_t   = (state == UP) ? (y_q - W'(1)) : (y_q + W'(1));
            rem_t = rem - RW'(1);
        end
        at_min = (y_t == YMIN_W);
        at_max = (y_t == YMAX_W);

        // Same-direction press adds STEP, saturating at the queue limit.
        rem_sum = int'(rem_t) + STEP;
        rem_add = (rem_sum > REM_MAX) ? RW'(REM_MAX) : RW'(rem_sum);

        if (FREEZE) begin
            state_n = IDLE;
            rem_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A tick in IDLE never moves the paddle.
                    if (up_only && !at_min) begin
                        state_n = UP;
                        rem_n   = STEP_R;
                        dir_n   = 1'b0;
                    end else if (dn_only && !at_max) begin
                        state_n = DOWN;
                        rem_n   = STEP_R;
                        dir_n   = 1'b1;
                    end
                end
                UP: begin
                    y_n = y_t;
                    if (dn_only && !at_max) begin
                        // Reverse; queued up-pixels are dropped.
                        state_n = DOWN;
                        rem_n   = STEP_R;
                        dir_n   = 1'b1;
                    end else if (up_only && !at_min) begin
                        rem_n = rem_add;
                    end else if (FRAME_TICK && ((rem_t == '0) || at_min)) begin
                        state_n = IDLE;
                        rem_n   = '0;
                    end else begin
                        rem_n = rem_t;
                    end
                end
                DOWN: begin
                    y_n = y_t;
                    if (up_only && !at_min) begin
                        state_n = UP;
                        rem_n   = STEP_R;
                        dir_n   = 1'b0;
                    end else if (dn_only && !at_max) begin
                        rem_n = rem_add;
                    end else if (FRAME_TICK && ((rem_t == '0) || at_max)) begin
                        state_n = IDLE;
                        rem_n   = '0;
                    end else begin
                        rem_n = rem_t;
                    end
                end
                default: begin
                    state_n = IDLE;
                    rem_n   = '0;
                end
            endcase
        end
    end

    assign PADDLE_Y = y_q;
    assign MOVING   = (state != IDLE);
    assign DIR      = dir_q;

endmodule

// File: tb/tb_paddle_controller.sv
// -----------------------------------------------------------------------------
// tb_paddle_controller
//
// Directed bench for paddle_controller with default parameters
// (Y_MIN=0, Y_MAX=400, Y_INIT=200, STEP=16, PEND_MAX=4). Inputs are driven
// 1 time unit after a rising edge and outputs are checked 1 time unit after
// the edge that samples them.
// -----------------------------------------------------------------------------
module tb_paddle_controller;

    logic       clk;
    logic       rst_n;
    logic       up_p;
    logic       dn_p;
    logic       frame_tick;
    logic       freeze;
    logic [9:0] paddle_y;
    logic       moving;
    logic       dir;

    int total;
    int bad;

    paddle_controller dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .UP_P       (up_p),
        .DN_P       (dn_p),
        .FRAME_TICK (frame_tick),
        .FREEZE     (freeze),
        .PADDLE_Y   (paddle_y),
        .MOVING     (moving),
        .DIR        (dir)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock cycle with the given strobes, then strobes return low
    task automatic cyc(input logic u, input logic d, input logic t);
        up_p       = u;
        dn_p       = d;
        frame_tick = t;
        @(posedge clk);
        #1;
        up_p       = 1'b0;
        dn_p       = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int y, input int mv, input int dr);
        chk({tag, ".y"}, int'(paddle_y), y);
        chk({tag, ".moving"}, int'(moving), mv);
        chk({tag, ".dir"}, int'(dir), dr);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        up_p       = 1'b0;
        dn_p       = 1'b0;
        frame_tick = 1'b0;
        freeze     = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 200, 0, 0);
        rst_n = 1'b1;

        // single press, 16 ticks: 200 -> 184
        cyc(1'b1, 1'b0, 1'b0);
        chk_all("up1.press", 200, 1, 0);
        ticks(15);
        chk_all("up1.t15", 185, 1, 0);
        ticks(1);
        chk_all("up1.t16", 184, 0, 0);

        // six presses 3 cycles apart: queue saturates at 64 pixels
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk_all("sat.queued", 184, 1, 0);
        ticks(63);
        chk_all("sat.t63", 121, 1, 0);
        ticks(1);
        chk_all("sat.t64", 120, 0, 0);
        ticks(1);
        chk_all("sat.t65", 120, 0, 0);

        // walk down to Y=8 with seven full moves
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            ticks(16);
        end
        chk_all("walk.y8", 8, 0, 0);

        // move clipped at Y_MIN
        cyc(1'b1, 1'b0, 1'b0);
        ticks(7);
        chk_all("clip.t7", 1, 1, 0);
        ticks(1);
        chk_all("clip.t8", 0, 0, 0);
        ticks(4);
        chk_all("clip.t12", 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_all("clip.press_at_min", 0, 0, 0);
        ticks(1);
        chk_all("clip.tick_at_min", 0, 0, 0);

        // asynchronous reset in the middle of a move
        cyc(1'b0, 1'b1, 1'b0);
        ticks(3);
        chk_all("arst.before", 3, 1, 1);
        rst_n = 1'b0;
        #1;
        chk_all("arst.async", 200, 0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("arst.released", 200, 0, 0);

        // reversal with a coincident tick
        cyc(1'b1, 1'b0, 1'b0);
        ticks(5);
        chk_all("rev.y195", 195, 1, 0);
        cyc(1'b0, 1'b1, 1'b1);
        chk_all("rev.turn", 194, 1, 1);
        ticks(15);
        chk_all("rev.t15", 209, 1, 1);
        ticks(1);
        chk_all("rev.t16", 210, 0, 1);

        // both pulses in IDLE: ignored
        cyc(1'b1, 1'b1, 1'b0);
        chk_all("both.idle", 210, 0, 1);
        ticks(1);
        chk_all("both.idle_tick", 210, 0, 1);

        // same-direction press with coincident tick: rem = 13-1+16 = 28
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        chk_all("acc.t3", 207, 1, 0);
        cyc(1'b1, 1'b0, 1'b1);
        chk_all("acc.press_tick", 206, 1, 0);
        ticks(27);
        chk_all("acc.t27", 179, 1, 0);
        ticks(1);
        chk_all("acc.t28", 178, 0, 0);

        // tick coincident with a press in IDLE does not move
        cyc(1'b1, 1'b0, 1'b1);
        chk_all("idle.press_tick", 178, 1, 0);
        ticks(2);
        chk_all("frz.before", 176, 1, 0);

        // freeze for 10 cycles with pulses and ticks
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       cyc(1'b0, 1'b1, 1'b1);
                1:       cyc(1'b1, 1'b0, 1'b1);
                default: cyc(1'b0, 1'b0, 1'b1);
            endcase
            chk_all($sformatf("frz.c%0d", i), 176, 0, 0);
        end
        freeze = 1'b0;
        ticks(1);
        chk_all("frz.after", 176, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
